// File: rtl/cpu_program_player_if.sv
// Host-side bundle of the program player: loader write port, run control,
// and the signals that drive the attached stack_cpu.
interface cpu_program_player_if #(
  parameter int ADDR_BITS = 4
) ();
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [3:0]           wr_data;
  logic                 start;
  logic                 cpu_rst;
  logic [3:0]           cpu_inbits;
  logic                 busy;
  logic                 done;
  logic [ADDR_BITS-1:0] pc;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  cpu_rst, cpu_inbits, busy, done, pc
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output cpu_rst, cpu_inbits, busy, done, pc
  );
endinterface

// File: rtl/cpu_program_player.sv
// Stores a nibble program and replays it onto stack_cpu inbits, holding each
// opcode/operand for the CPU's fetch/exec timing; pulses the CPU reset at run start.
module cpu_program_player #(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_program_player_if.slave  host
);
  localparam int                DEPTH    = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] STEP_ONE = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS:0] STEP_TWO = (ADDR_BITS + 1)'(2);
  localparam logic [3:0]         OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CPURST = 3'd1,
    S_FETCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic has_operand(input logic [3:0] op);
    case (op)
      4'h1, 4'h6, 4'h7, 4'h8: has_operand = 1'b1;
      default:                has_operand = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] exec_len(input logic [3:0] op);
    case (op)
      4'h0, 4'h3, 4'h4, 4'hB, 4'hE: exec_len = 2'd1;
      4'h9, 4'hA, 4'hC, 4'hD:       exec_len = 2'd3;
      default:                      exec_len = 2'd2;
    endcase
  endfunction

  logic [3:0]           mem_q [DEPTH];
  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d;
  logic [3:0]           op_q, op_d;
  logic [1:0]           exec_cnt_q, exec_cnt_d;
  logic [3:0]           inbits_q, inbits_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [ADDR_BITS:0]   adv_sum_s;
  logic [ADDR_BITS-1:0] adv_pc_s;
  logic [ADDR_BITS-1:0] operand_addr_s;
  logic                 wrap_s;
  logic [3:0]           fetch_op_s;
  logic [3:0]           operand_s;
  logic                 wr_accept_s;

  // Carry out of the pc advance marks a run that fell off the end of the RAM.
  assign adv_sum_s      = {1'b0, pc_q} + (has_operand(op_q) ? STEP_TWO : STEP_ONE);
  assign adv_pc_s       = adv_sum_s[ADDR_BITS-1:0];
  assign wrap_s         = adv_sum_s[ADDR_BITS];
  assign operand_addr_s = pc_q + ADDR_BITS'(1);
  assign operand_s      = has_operand(op_q) ? mem_q[operand_addr_s] : 4'h0;
  assign fetch_op_s     = mem_q[(state_q == S_EXEC) ? adv_pc_s : pc_q];
  assign wr_accept_s    = host.wr_en && (state_q == S_IDLE);

  // Program RAM write port, open only while idle.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_q[host.wr_addr] <= host.wr_data;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    exec_cnt_d = exec_cnt_q;
    inbits_d   = 4'h0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (host.start) begin
          state_d = S_CPURST;
          pc_d    = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CPURST: begin
        state_d = S_FETCH;
        busy_d  = 1'b1;
        op_d    = fetch_op_s;
        if (fetch_op_s == OP_HALT) begin
          done_d = 1'b1;
        end else begin
          inbits_d = fetch_op_s;
        end
      end
      S_FETCH: begin
        if (op_q == OP_HALT) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_EXEC;
          exec_cnt_d = exec_len(op_q);
          busy_d     = 1'b1;
          inbits_d   = operand_s;
        end
      end
      S_EXEC: begin
        busy_d = 1'b1;
        if (exec_cnt_q > 2'd1) begin
          exec_cnt_d = exec_cnt_q - 2'd1;
          inbits_d   = inbits_q;
        end else if (wrap_s) begin
          state_d = S_DONE;
          pc_d    = '0;
          done_d  = 1'b1;
        end else begin
          state_d = S_FETCH;
          pc_d    = adv_pc_s;
          op_d    = fetch_op_s;
          if (fetch_op_s == OP_HALT) begin
            done_d = 1'b1;
          end else begin
            inbits_d = fetch_op_s;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      op_q       <= 4'h0;
      exec_cnt_q <= 2'd0;
      inbits_q   <= 4'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      exec_cnt_q <= exec_cnt_d;
      inbits_q   <= inbits_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // The CPU is held in reset together with this block, and for the run's first cycle.
  assign host.cpu_rst    = rst | (state_q == S_CPURST);
  assign host.cpu_inbits = inbits_q;
  assign host.busy       = busy_q;
  assign host.done       = done_q;
  assign host.pc         = pc_q;
endmodule

// File: tb/tb_cpu_program_player.sv
// Bench for cpu_program_player: replays directed and random programs and compares
// every cycle of the run against a program-interpreter reference model.
module tb_cpu_program_player;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total_checks  = 0;
  int   passed_checks = 0;

  always #5 clk = ~clk;

  cpu_program_player_if #(.ADDR_BITS(4)) bus ();
  cpu_program_player_if #(.ADDR_BITS(2)) bus2 ();

  cpu_program_player #(.ADDR_BITS(4)) dut  (.clk(clk), .rst(rst), .host(bus));
  cpu_program_player #(.ADDR_BITS(2)) dut2 (.clk(clk), .rst(rst), .host(bus2));

  // Bench copies of what each program RAM should hold.
  logic [3:0] shadow  [16];
  logic [3:0] shadow2 [16];

  // Trace word: {cpu_rst, cpu_inbits[3:0], busy, done, pc[3:0]}
  logic [10:0] exp_q [$];
  logic [10:0] obs_q [$];

  function automatic int exec_cycles(input int op);
    case (op)
      0, 3, 4, 11, 14: return 1;
      9, 10, 12, 13:   return 3;
      default:         return 2;
    endcase
  endfunction

  // Interprets the program and lists what each cycle after start should show.
  task automatic build_exp(input logic [3:0] ram [16], input int depth, output logic [10:0] exp [$]);
    int  pc;
    int  op;
    int  len;
    bit  fin;
    logic [3:0] opnd;
    exp = {};
    exp.push_back({1'b1, 4'h0, 1'b1, 1'b0, 4'h0});
    pc  = 0;
    fin = 1'b0;
    for (int guard = 0; guard < 64 && !fin; guard++) begin
      op = int'(ram[pc]);
      if (op == 15) begin
        exp.push_back({1'b0, 4'h0, 1'b1, 1'b1, 4'(pc)});
        exp.push_back({1'b0, 4'h0, 1'b0, 1'b0, 4'(pc)});
        fin = 1'b1;
      end else begin
        len  = (op == 1 || op == 6 || op == 7 || op == 8) ? 2 : 1;
        opnd = (len == 2) ? ram[(pc + 1) % depth] : 4'h0;
        exp.push_back({1'b0, 4'(op), 1'b1, 1'b0, 4'(pc)});
        for (int k = 0; k < exec_cycles(op); k++) begin
          exp.push_back({1'b0, opnd, 1'b1, 1'b0, 4'(pc)});
        end
        pc = pc + len;
        if (pc >= depth) begin
          exp.push_back({1'b0, 4'h0, 1'b1, 1'b1, 4'h0});
          exp.push_back({1'b0, 4'h0, 1'b0, 1'b0, 4'h0});
          fin = 1'b1;
        end
      end
    end
  endtask

  task automatic load_prog(input logic [63:0] pw, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'(i);
      bus.wr_data = pw[4*i +: 4];
      shadow[i]   = pw[4*i +: 4];
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic load_prog2(input logic [15:0] pw);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus2.wr_en   = 1'b1;
      bus2.wr_addr = 2'(i);
      bus2.wr_data = pw[4*i +: 4];
      shadow2[i]   = pw[4*i +: 4];
    end
    @(negedge clk);
    bus2.wr_en = 1'b0;
  endtask

  // Starts a run and records n cycles; at indices inj_a/inj_b pulses start and a write.
  task automatic capture(input int n, input int inj_a, input int inj_b,
                         input bit first_wr, input logic [3:0] first_data,
                         output logic [10:0] obs [$]);
    obs = {};
    @(negedge clk);
    bus.start = 1'b1;
    if (first_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'd0;
      bus.wr_data = first_data;
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      obs.push_back({bus.cpu_rst, bus.cpu_inbits, bus.busy, bus.done, bus.pc});
      if (k == inj_a || k == inj_b) begin
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd2;
        bus.wr_data = ~shadow[2];
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic capture2(input int n, output logic [10:0] obs [$]);
    obs = {};
    @(negedge clk);
    bus2.start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus2.start = 1'b0;
      obs.push_back({bus2.cpu_rst, bus2.cpu_inbits, bus2.busy, bus2.done, 2'b00, bus2.pc});
    end
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b0; bus.start = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 4'h0;
    bus2.wr_en = 1'b0; bus2.start = 1'b0; bus2.wr_addr = 2'd0; bus2.wr_data = 4'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_checks++;
    if ({bus.cpu_rst, bus.cpu_inbits, bus.busy, bus.done, bus.pc} !== 11'b1_0000_0_0_0000) begin
      $display("FAIL reset_state: got %b want %b", {bus.cpu_rst, bus.cpu_inbits, bus.busy, bus.done, bus.pc}, 11'b1_0000_0_0_0000);
    end else passed_checks++;
    rst = 1'b0;
    @(negedge clk);
    total_checks++;
    if ({bus.cpu_rst, bus.busy, bus2.cpu_rst, bus2.busy, bus2.pc} !== 6'b0) begin
      $display("FAIL reset_release: got %b want %b", {bus.cpu_rst, bus.busy, bus2.cpu_rst, bus2.busy, bus2.pc}, 6'b0);
    end else passed_checks++;
  endtask

  task automatic test_basic_push();
    logic [3:0] want_in [7] = '{4'h0, 4'h1, 4'h5, 4'h5, 4'h3, 4'h0, 4'h0};
    load_prog(64'hF351, 4);
    build_exp(shadow, 16, exp_q);
    capture(exp_q.size(), -1, -1, 1'b0, 4'h0, obs_q);
    for (int i = 0; i < exp_q.size(); i++) begin
      total_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL basic_trace c%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      else passed_checks++;
    end
    for (int i = 0; i < 7; i++) begin
      total_checks++;
      if (obs_q[i][9:6] !== want_in[i]) $display("FAIL basic_inbits c%0d: got %h want %h", i + 1, obs_q[i][9:6], want_in[i]);
      else passed_checks++;
    end
    total_checks++;
    if ({obs_q[0][10], obs_q[1][10], obs_q[6][4], obs_q[5][4]} !== 4'b1010) begin
      $display("FAIL basic_rst_done: got %b want 1010", {obs_q[0][10], obs_q[1][10], obs_q[6][4], obs_q[5][4]});
    end else passed_checks++;
  endtask

  task automatic test_add_out();
    load_prog(64'hF43083171, 9);
    build_exp(shadow, 16, exp_q);
    capture(exp_q.size(), -1, -1, 1'b0, 4'h0, obs_q);
    for (int i = 0; i < exp_q.size(); i++) begin
      total_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL add_trace c%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      else passed_checks++;
    end
    total_checks++;
    if ({obs_q[obs_q.size()-2][5:4], obs_q[obs_q.size()-1][5:4]} !== 4'b1100) begin
      $display("FAIL add_busy_fall: got %b want 1100", {obs_q[obs_q.size()-2][5:4], obs_q[obs_q.size()-1][5:4]});
    end else passed_checks++;
  endtask

  task automatic test_mult_pc();
    int pcs [$];
    int want_pcs [5] = '{0, 2, 4, 5, 6};
    int mult_cycles;
    load_prog(64'hF394131, 7);
    build_exp(shadow, 16, exp_q);
    capture(exp_q.size(), -1, -1, 1'b0, 4'h0, obs_q);
    for (int i = 0; i < exp_q.size(); i++) begin
      total_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL mult_trace c%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      else passed_checks++;
    end
    pcs = {};
    mult_cycles = 0;
    for (int i = 1; i < obs_q.size(); i++) begin
      if (obs_q[i][5] && (pcs.size() == 0 || pcs[pcs.size()-1] != int'(obs_q[i][3:0]))) pcs.push_back(int'(obs_q[i][3:0]));
      if (obs_q[i][5] && obs_q[i][3:0] == 4'd4 && obs_q[i][9:6] == 4'h0) mult_cycles++;
    end
    total_checks++;
    if (pcs.size() != 5) $display("FAIL mult_pc_count: got %0d want 5", pcs.size());
    else passed_checks++;
    for (int i = 0; i < 5 && i < pcs.size(); i++) begin
      total_checks++;
      if (pcs[i] != want_pcs[i]) $display("FAIL mult_pc_seq %0d: got %0d want %0d", i, pcs[i], want_pcs[i]);
      else passed_checks++;
    end
    total_checks++;
    if (mult_cycles != 3) $display("FAIL mult_hold: got %0d want 3", mult_cycles);
    else passed_checks++;
  endtask

  task automatic test_wrap();
    logic [15:0] progs [2] = '{16'h1000, 16'h1003};
    int dn;
    for (int p = 0; p < 2; p++) begin
      load_prog2(progs[p]);
      build_exp(shadow2, 4, exp_q);
      capture2(exp_q.size(), obs_q);
      dn = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        total_checks++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL wrap_trace p%0d c%0d: got %b want %b", p, i + 1, obs_q[i], exp_q[i]);
        else passed_checks++;
        if (obs_q[i][4]) dn++;
      end
      total_checks++;
      if (dn != 1 || obs_q.size() != 12 || obs_q[10][4] !== 1'b1) begin
        $display("FAIL wrap_done p%0d: got %0d pulses want 1 at c11", p, dn);
      end else passed_checks++;
    end
  endtask

  task automatic test_rst_mid_run();
    load_prog(64'hF351, 4);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_checks++;
    if (bus.cpu_inbits !== 4'h5) $display("FAIL rst_pre_inbits: got %h want 5", bus.cpu_inbits);
    else passed_checks++;
    rst = 1'b1;
    #1;
    total_checks++;
    if (bus.cpu_rst !== 1'b1) $display("FAIL rst_passthru: got %b want 1", bus.cpu_rst);
    else passed_checks++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_checks++;
    if ({bus.cpu_rst, bus.cpu_inbits, bus.busy, bus.done, bus.pc} !== 11'b0) begin
      $display("FAIL rst_idle: got %b want %b", {bus.cpu_rst, bus.cpu_inbits, bus.busy, bus.done, bus.pc}, 11'b0);
    end else passed_checks++;
    build_exp(shadow, 16, exp_q);
    capture(exp_q.size(), -1, -1, 1'b0, 4'h0, obs_q);
    for (int i = 0; i < exp_q.size(); i++) begin
      total_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rst_replay c%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      else passed_checks++;
    end
  endtask

  task automatic test_busy_ignore();
    load_prog(64'hF394131, 7);
    build_exp(shadow, 16, exp_q);
    capture(exp_q.size(), 2, exp_q.size() - 2, 1'b0, 4'h0, obs_q);
    for (int i = 0; i < exp_q.size(); i++) begin
      total_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL ignore_trace c%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      else passed_checks++;
    end
    total_checks++;
    if ({bus.cpu_rst, bus.busy} !== 2'b00) $display("FAIL ignore_no_restart: got %b want 00", {bus.cpu_rst, bus.busy});
    else passed_checks++;
    capture(exp_q.size(), -1, -1, 1'b0, 4'h0, obs_q);
    for (int i = 0; i < exp_q.size(); i++) begin
      total_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL ignore_readback c%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      else passed_checks++;
    end
  endtask

  task automatic test_write_with_start();
    load_prog(64'hF351, 4);
    shadow[0] = 4'h3;
    build_exp(shadow, 16, exp_q);
    capture(exp_q.size(), -1, -1, 1'b1, 4'h3, obs_q);
    for (int i = 0; i < exp_q.size(); i++) begin
      total_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL wr_start c%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      else passed_checks++;
    end
  endtask

  task automatic test_random();
    logic [63:0] pw;
    int idx;
    for (int it = 0; it < 20; it++) begin
      pw = {$urandom, $urandom};
      if (it % 2 == 0) begin
        idx = int'($urandom_range(0, 15));
        pw[4*idx +: 4] = 4'hF;
      end
      load_prog(pw, 16);
      build_exp(shadow, 16, exp_q);
      capture(exp_q.size(), -1, -1, 1'b0, 4'h0, obs_q);
      for (int i = 0; i < exp_q.size(); i++) begin
        total_checks++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL rand_trace it%0d c%0d: got %b want %b", it, i + 1, obs_q[i], exp_q[i]);
        else passed_checks++;
      end
    end
    for (int it = 0; it < 8; it++) begin
      load_prog2(16'($urandom));
      build_exp(shadow2, 4, exp_q);
      capture2(exp_q.size(), obs_q);
      for (int i = 0; i < exp_q.size(); i++) begin
        total_checks++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL rand_small it%0d c%0d: got %b want %b", it, i + 1, obs_q[i], exp_q[i]);
        else passed_checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_push();
    test_add_out();
    test_mult_pc();
    test_wrap();
    test_rst_mid_run();
    test_busy_ignore();
    test_write_with_start();
    test_random();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end
endmodule
